hash_mem_responder: RTL and testbench

//  Memory-side responder and host harness for the bitcoin hash engine. Owns a word RAM and serves the

---
 rtl/hash_mem_pkg.sv | 20 ++
 rtl/hash_word_ram.sv | 32 +++
 rtl/hash_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_hash_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_mem_pkg.sv
// Shared types and default sizing for the hash-engine memory responder.
package hash_mem_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, READY, START, RUN, DRD, DVAL} state_t;

   typedef logic [31:0] word_t;

   localparam int unsigned DefDepth         = 64;
   localparam int unsigned DefMsgBase       = 0;
   localparam int unsigned DefMsgWords      = 20;
   localparam int unsigned DefOutBase       = 32;
   localparam int unsigned DefNumNonces     = 16;
   localparam int unsigned DefTimeoutCycles = 4096;

   // Index width for a range of n values, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hash_word_ram.sv
// Single-port synchronous word RAM; registered read returns the pre-write word.
module hash_word_ram
   import hash_mem_pkg::*;
#(
   parameter  int unsigned DEPTH = DefDepth,
   localparam int unsigned AW    = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  word_t         i_wdata,
   output word_t         o_rdata
);

   word_t r_mem [DEPTH];
   word_t r_rdata;

   // Storage is deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/hash_mem_responder.sv
// Host load / engine launch / result drain around a word RAM shared with the hash engine.
module hash_mem_responder
   import hash_mem_pkg::*;
#(
   parameter int unsigned DEPTH          = DefDepth,
   parameter int unsigned MSG_BASE       = DefMsgBase,
   parameter int unsigned MSG_WORDS      = DefMsgWords,
   parameter int unsigned OUT_BASE       = DefOutBase,
   parameter int unsigned NUM_NONCES     = DefNumNonces,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  word_t       i_ld_data,
   input  logic        i_ld_last,
   input  logic        i_go,
   output logic        o_eng_start,
   input  logic        i_eng_done,
   output logic [15:0] o_message_addr,
   output logic [15:0] o_output_addr,
   input  logic        i_mem_we,
   input  logic [15:0] i_mem_addr,
   input  word_t       i_mem_write_data,
   output word_t       o_mem_read_data,
   output logic        o_res_valid,
   input  logic        i_res_ready,
   output word_t       o_res_data,
   output logic        o_res_last,
   output logic        o_busy,
   output logic        o_timeout,
   output logic        o_addr_err
);

   localparam int unsigned AW    = cnt_w(DEPTH);
   localparam int unsigned IdxW  = $clog2(MSG_WORDS + 1);
   localparam int unsigned RidxW = cnt_w(NUM_NONCES);
   localparam int unsigned TcntW = cnt_w(TIMEOUT_CYCLES);

   state_t             r_state, w_state_next;
   logic [IdxW-1:0]    r_idx;
   logic [RidxW-1:0]   r_ridx;
   logic [TcntW-1:0]   r_tcnt;
   logic               r_timeout, r_addr_err, r_eng_rd, r_oor;
   word_t              r_mem_hold;

   logic               w_ld_fire, w_in_range, w_ld_done, w_last_res, w_tmo_hit;
   logic               w_ram_we, w_ram_re;
   logic [AW-1:0]      w_ram_addr;
   word_t              w_ram_wdata, w_rdata;

   assign w_ld_fire  = i_ld_valid && o_ld_ready;
   assign w_in_range = i_mem_addr < 16'(DEPTH);
   assign w_ld_done  = i_ld_last || (r_idx == IdxW'(MSG_WORDS - 1));
   assign w_last_res = r_ridx == RidxW'(NUM_NONCES - 1);
   assign w_tmo_hit  = r_tcnt == TcntW'(TIMEOUT_CYCLES - 1);

   assign o_message_addr = 16'(MSG_BASE);
   assign o_output_addr  = 16'(OUT_BASE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (i_ld_valid) w_state_next = (i_ld_last || MSG_WORDS == 1) ? READY : LOAD;
         LOAD:    if (i_ld_valid && w_ld_done) w_state_next = READY;
         READY:   if (i_go) w_state_next = START;
         START:   w_state_next = RUN;
         RUN: begin
            if (i_eng_done)     w_state_next = DRD;
            else if (w_tmo_hit) w_state_next = IDLE;
         end
         DRD:     w_state_next = DVAL;
         DVAL:    if (i_res_ready) w_state_next = w_last_res ? IDLE : DRD;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_ld_ready  = reset_n && (r_state == IDLE || r_state == LOAD);
      o_eng_start = r_state == START;
      o_busy      = r_state != IDLE;
      o_res_valid = r_state == DVAL;
      o_res_last  = (r_state == DVAL) && w_last_res;
      o_res_data  = (r_state == DVAL) ? w_rdata : '0;
      o_timeout   = r_timeout;
      o_addr_err  = r_addr_err;
      // Live RAM data only on the cycle after an engine access; otherwise the held copy.
      o_mem_read_data = r_eng_rd ? (r_oor ? '0 : w_rdata) : r_mem_hold;

      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = AW'(MSG_BASE) + AW'(r_idx);
      w_ram_wdata = i_ld_data;
      case (r_state)
         IDLE: begin
            w_ram_we   = i_ld_valid;
            w_ram_addr = AW'(MSG_BASE);
         end
         LOAD: w_ram_we = i_ld_valid;
         RUN: begin
            w_ram_we    = i_mem_we && w_in_range;
            w_ram_re    = w_in_range;
            w_ram_addr  = i_mem_addr[AW-1:0];
            w_ram_wdata = i_mem_write_data;
         end
         DRD: begin
            w_ram_re   = 1'b1;
            w_ram_addr = AW'(OUT_BASE) + AW'(r_ridx);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx      <= '0;
         r_ridx     <= '0;
         r_tcnt     <= '0;
         r_timeout  <= 1'b0;
         r_addr_err <= 1'b0;
         r_eng_rd   <= 1'b0;
         r_oor      <= 1'b0;
         r_mem_hold <= '0;
      end else begin
         r_eng_rd   <= r_state == RUN;
         r_oor      <= (r_state == RUN) && !w_in_range;
         r_mem_hold <= o_mem_read_data;
         case (r_state)
            IDLE:  r_idx <= w_ld_fire ? IdxW'(1) : '0;
            LOAD:  if (w_ld_fire) r_idx <= r_idx + IdxW'(1);
            START: r_tcnt <= '0;
            RUN: begin
               r_ridx <= '0;
               if (!w_tmo_hit) r_tcnt <= r_tcnt + TcntW'(1);
               if (!w_in_range) r_addr_err <= 1'b1;
               if (!i_eng_done && w_tmo_hit) r_timeout <= 1'b1;
            end
            DVAL:  if (i_res_ready && !w_last_res) r_ridx <= r_ridx + RidxW'(1);
            default: ;
         endcase
         if (w_ld_fire) begin
            r_timeout  <= 1'b0;
            r_addr_err <= 1'b0;
         end
      end
   end

   hash_word_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_hash_mem_responder.sv
// Scoreboard bench: load, engine accesses, drain, timeout and reset for hash_mem_responder.
module tb_hash_mem_responder;
   import hash_mem_pkg::*;

   localparam int unsigned TO = 2048;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ld_valid = 0, ld_last = 0, go = 0, eng_done = 0, mem_we = 0, res_ready = 0;
   word_t       ld_data = '0, mem_write_data = '0;
   logic [15:0] mem_addr = '0;
   logic        ld_ready, eng_start, res_valid, res_last, busy, timeout, addr_err;
   logic [15:0] message_addr, output_addr;
   word_t       mem_read_data, res_data;

   int    n_total = 0;
   int    n_bad = 0;
   int    cyc = 0;
   word_t rd_q[$];
   word_t res_q[$];
   word_t msg_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hash_mem_responder #(
      .DEPTH          (64),
      .MSG_BASE       (0),
      .MSG_WORDS      (20),
      .OUT_BASE       (32),
      .NUM_NONCES     (16),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_ld_valid       (ld_valid),
      .o_ld_ready       (ld_ready),
      .i_ld_data        (ld_data),
      .i_ld_last        (ld_last),
      .i_go             (go),
      .o_eng_start      (eng_start),
      .i_eng_done       (eng_done),
      .o_message_addr   (message_addr),
      .o_output_addr    (output_addr),
      .i_mem_we         (mem_we),
      .i_mem_addr       (mem_addr),
      .i_mem_write_data (mem_write_data),
      .o_mem_read_data  (mem_read_data),
      .o_res_valid      (res_valid),
      .i_res_ready      (res_ready),
      .o_res_data       (res_data),
      .o_res_last       (res_last),
      .o_busy           (busy),
      .o_timeout        (timeout),
      .o_addr_err       (addr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input word_t d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic eng_write(input logic [15:0] a, input word_t d);
      mem_we         = 1'b1;
      mem_addr       = a;
      mem_write_data = d;
      tick();
      mem_we = 1'b0;
   endtask

   task automatic eng_read(input string tag, input logic [15:0] a, input word_t exp);
      mem_we   = 1'b0;
      mem_addr = a;
      rd_q.push_back(exp);
      tick();
      check(tag, mem_read_data, rd_q.pop_front());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1);
   end

   initial begin
      int    run_start;
      int    got;
      int    budget;
      int    seen;
      word_t exp;

      // Reset state
      repeat (2) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_ld_ready", 32'(ld_ready), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_rd_data", mem_read_data, 0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_addr_err", 32'(addr_err), 0);
      check("msg_addr", 32'(message_addr), 0);
      check("out_addr", 32'(output_addr), 32);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("idle_ld_ready", 32'(ld_ready), 1);

      // Load 20 words, the last flagged
      for (int i = 0; i < 20; i++) begin
         exp = 32'hC0DE_0000 + 32'(i);
         msg_q.push_back(exp);
         load_word(exp, i == 19);
         if (i == 0) check("load_busy", 32'(busy), 1);
      end
      check("ready_ld_ready", 32'(ld_ready), 0);
      ld_valid = 1'b1;
      ld_data  = 32'hDEAD_BEEF;
      tick();
      ld_valid = 1'b0;
      check("w21_ld_ready", 32'(ld_ready), 0);

      // Done outside RUN is ignored
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("done_ign", 32'(res_valid), 0);
      check("done_ign_busy", 32'(busy), 1);

      go = 1'b1;
      tick();
      go = 1'b0;
      check("start_pulse", 32'(eng_start), 1);
      tick();
      check("start_once", 32'(eng_start), 0);
      run_start = cyc;

      for (int i = 0; i < 20; i++) eng_read("msg_word", 16'(i), msg_q.pop_front());
      mem_addr = 16'd20;
      tick();
      check("no_w21", 32'(mem_read_data == 32'hDEAD_BEEF), 0);

      eng_write(16'd5, 32'hA5A5_0005);
      eng_read("latency", 16'd5, 32'hA5A5_0005);

      eng_write(16'd7, 32'h0);
      mem_we         = 1'b1;
      mem_addr       = 16'd7;
      mem_write_data = 32'h1234;
      rd_q.push_back(32'h0);
      tick();
      mem_we = 1'b0;
      check("raw_old", mem_read_data, rd_q.pop_front());
      eng_read("raw_new", 16'd7, 32'h1234);

      eng_write(16'd6, 32'h6666_0006);
      check("pre_addr_err", 32'(addr_err), 0);
      eng_write(16'd70, 32'hBAD0_0070);
      check("addr_err", 32'(addr_err), 1);
      eng_read("oor_read", 16'd70, 32'h0);
      eng_read("no_alias", 16'd6, 32'h6666_0006);

      for (int i = 0; i < 16; i++) begin
         exp = 32'hB17C_0000 + 32'(i);
         res_q.push_back(exp);
         eng_write(16'(32 + i), exp);
      end
      mem_addr = 16'd0;
      while (cyc - run_start < 999) tick();
      check("run_busy", 32'(busy), 1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;

      // Drain
      got    = 0;
      budget = 0;
      while (got < 16 && budget < 200) begin
         if (res_valid) begin
            exp = res_q.pop_front();
            check("res_data", res_data, exp);
            check("res_last", 32'(res_last), 32'(got == 15));
            if (got == 3) begin
               repeat (3) begin
                  tick();
                  check("hold_valid", 32'(res_valid), 1);
                  check("hold_data", res_data, exp);
               end
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("res_gap", 32'(res_valid), 0);
            got++;
         end else begin
            tick();
            budget++;
         end
      end
      check("drain_cnt", 32'(got), 16);
      check("drain_idle", 32'(busy), 0);
      check("err_sticky", 32'(addr_err), 1);
      check("rd_hold", mem_read_data, 32'hC0DE_0000);

      // Timeout
      load_word(32'h1111, 1'b1);
      check("err_clear", 32'(addr_err), 0);
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      seen = 0;
      repeat (TO - 1) begin
         tick();
         if (res_valid) seen++;
      end
      check("to_pre_busy", 32'(busy), 1);
      check("to_pre_flag", 32'(timeout), 0);
      tick();
      check("to_idle", 32'(busy), 0);
      check("to_flag", 32'(timeout), 1);
      check("to_no_valid", 32'(seen), 0);
      load_word(32'h2222, 1'b1);
      check("to_clear", 32'(timeout), 0);

      // Reset mid-drain
      go = 1'b1;
      tick();
      go = 1'b0;
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      check("dval_valid", 32'(res_valid), 1);
      check("dval_data", res_data, 32'hB17C_0000);
      reset_n = 1'b0;
      #1;
      check("ar_valid", 32'(res_valid), 0);
      check("ar_data", res_data, 0);
      check("ar_last", 32'(res_last), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_ld_ready", 32'(ld_ready), 0);
      check("ar_rd_data", mem_read_data, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post_rst_idle", 32'(busy), 0);
      check("post_rst_ready", 32'(ld_ready), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
